// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/stall controller for the 5-stage CPU
//
// Purpose: drives the load enables (*_we) and synchronous clears (*_flush) of
// the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It freezes,
// bubbles or squashes stages for the following events, highest priority first:
// halt, data-memory wait, multi-cycle mul/div, taken branch, load-use.
// It also counts the stall cycles.
//
// Ports:
//   clk, rst_n                  clock (rising edge); asynchronous active-low reset
//   id_rs, id_rt                source registers of the ID instruction
//   id_uses_rs, id_uses_rt      ID instruction really reads rs / rt
//   ex_rd, ex_mem_read          EX destination register; EX is a load
//   ex_md_start                 EX is a mul/div (sampled in RUN only)
//   branch_taken                EX branch/jump resolved taken
//   dmem_stall                  MEM access not complete this cycle
//   halt                        halt/syscall retiring in WB
//   pc_we .. memwb_we           load enables (combinational)
//   ifid_flush .. memwb_flush   synchronous clears (combinational)
//   busy                        FSM not in RUN
//   stall_cycles                cycles with pc_we=0 since reset (wraps)
module hazard_ctrl #(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_md_start,
    input  logic             branch_taken,
    input  logic             dmem_stall,
    input  logic             halt,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MW = $clog2(MD_CYCLES + 1);
    localparam logic [MW-1:0] MD_LOAD = MW'(MD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MD_WAIT = 2'd1,
        S_HALTED  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [MW-1:0] md_cnt, md_cnt_nxt;
    logic          md_go;
    logic          md_stall;
    logic          load_use;

    // A taken branch squashes the mul/div in EX, so it must not start one.
    assign md_go    = (state == S_RUN) && ex_md_start && !branch_taken;
    assign md_stall = (state == S_MD_WAIT) || md_go;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) ||
                       (id_uses_rt && (id_rt == ex_rd)));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_RUN;
            md_cnt       <= '0;
            stall_cycles <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            if ((state != S_HALTED) && !pc_we)
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    // Next-state logic. dmem_stall deliberately has no effect here: the
    // mul/div unit keeps counting while memory is waiting.
    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        case (state)
            S_RUN: begin
                if (halt) begin
                    state_nxt = S_HALTED;
                end else if (md_go && (MD_CYCLES > 1)) begin
                    // The start cycle is the first stall cycle.
                    state_nxt  = S_MD_WAIT;
                    md_cnt_nxt = MD_LOAD;
                end
            end
            S_MD_WAIT: begin
                if (halt) begin
                    state_nxt  = S_HALTED;
                    md_cnt_nxt = '0;
                end else begin
                    md_cnt_nxt = md_cnt - MW'(1);
                    if (md_cnt == MW'(1))
                        state_nxt = S_RUN;
                end
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_RUN;
        endcase
    end

    // Output logic. Where a flush is raised, the matching we stays 1; the
    // register's clear has priority over its load anyway.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (!rst_n || (state == S_HALTED)) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
        end else if (dmem_stall) begin
            // Freeze everything upstream of MEM; bubble into WB.
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_flush = 1'b1;
        end else if (md_stall) begin
            // Hold IF..EX; bubble into MEM; let older instructions drain.
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_flush = 1'b1;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign busy = rst_n && (state != S_RUN);

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl (MD_CYCLES=4 and 1)
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rs, id_uses_rt, ex_mem_read, ex_md_start;
    logic       branch_taken, dmem_stall, halt;

    // Control vector: {pc,ifid,idex,exmem,memwb}_we, {ifid,idex,exmem,memwb}_flush
    logic [8:0]  ctl0, ctl1;
    logic        busy0, busy1;
    logic [31:0] cnt0, cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [8:0] C_IDLE   = 9'b11111_0000;
    localparam logic [8:0] C_LU     = 9'b00111_0100;
    localparam logic [8:0] C_BR     = 9'b11111_1100;
    localparam logic [8:0] C_MD     = 9'b00011_0010;
    localparam logic [8:0] C_DMEM   = 9'b00001_0001;
    localparam logic [8:0] C_OFF    = 9'b00000_0000;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_CYCLES(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_md_start(ex_md_start),
        .branch_taken(branch_taken), .dmem_stall(dmem_stall), .halt(halt),
        .pc_we(ctl0[8]), .ifid_we(ctl0[7]), .idex_we(ctl0[6]), .exmem_we(ctl0[5]),
        .memwb_we(ctl0[4]), .ifid_flush(ctl0[3]), .idex_flush(ctl0[2]),
        .exmem_flush(ctl0[1]), .memwb_flush(ctl0[0]),
        .busy(busy0), .stall_cycles(cnt0)
    );

    hazard_ctrl #(.MD_CYCLES(1), .CNT_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_md_start(ex_md_start),
        .branch_taken(branch_taken), .dmem_stall(dmem_stall), .halt(halt),
        .pc_we(ctl1[8]), .ifid_we(ctl1[7]), .idex_we(ctl1[6]), .exmem_we(ctl1[5]),
        .memwb_we(ctl1[4]), .ifid_flush(ctl1[3]), .idex_flush(ctl1[2]),
        .exmem_flush(ctl1[1]), .memwb_flush(ctl1[0]),
        .busy(busy1), .stall_cycles(cnt1)
    );

    // Reference model: per instance, remaining mul/div wait cycles, halted flag
    // and stall counter, evaluated from the priority rules.
    int          md_of  [2] = '{4, 1};
    int          m_left [2];
    bit          m_halt [2];
    logic [31:0] m_cnt  [2];
    logic [8:0]  e_ctl  [2];
    logic        e_busy [2];

    function automatic logic [8:0] model_ctl(int k);
        bit md, lu;
        if (!rst_n || m_halt[k]) return C_OFF;
        md = (m_left[k] > 0) || (ex_md_start && !branch_taken);
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        if (dmem_stall)        return C_DMEM;
        else if (md)           return C_MD;
        else if (branch_taken) return C_BR;
        else if (lu)           return C_LU;
        return C_IDLE;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0;
            m_halt[k] = 1'b0;
            m_cnt[k]  = '0;
        end
    endtask

    task automatic eval_model();
        for (int k = 0; k < 2; k++) begin
            e_ctl[k]  = model_ctl(k);
            e_busy[k] = rst_n && (m_halt[k] || m_left[k] > 0);
        end
    endtask

    // Apply inputs right after an edge, then settle and compute expectations.
    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic [4:0] rd, input logic mr,
                          input logic ms, input logic bt, input logic ds, input logic h);
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        ex_rd = rd; ex_mem_read = mr; ex_md_start = ms;
        branch_taken = bt; dmem_stall = ds; halt = h;
        #3;
        eval_model();
    endtask

    task automatic idle_in();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one clock; the model advances with the same pre-edge inputs.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (!m_halt[k]) begin
                    if (!e_ctl[k][8]) m_cnt[k] = m_cnt[k] + 1;
                    if (halt) begin
                        m_halt[k] = 1'b1;
                        m_left[k] = 0;
                    end else if (m_left[k] > 0) begin
                        m_left[k] = m_left[k] - 1;
                    end else if (ex_md_start && !branch_taken) begin
                        m_left[k] = md_of[k] - 1;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_in();
        model_reset();
        n_cmp++;
        if (ctl0 !== C_OFF || busy0 !== 1'b0 || cnt0 !== 32'd0) begin
            n_bad++;
            $display("FAIL reset: ctl=%b busy=%b cnt=%0d, want ctl=%b busy=0 cnt=0", ctl0, busy0, cnt0, C_OFF);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_in();
        n_cmp++;
        if (ctl0 !== C_IDLE || busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: ctl=%b busy=%b, want ctl=%b busy=0", ctl0, busy0, C_IDLE);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (ctl0 !== C_LU || cnt0 !== 32'd0) begin
            n_bad++;
            $display("FAIL load_use: ctl=%b cnt=%0d, want ctl=%b cnt=0", ctl0, cnt0, C_LU);
        end
        tick();
        // rt path, second operand
        set_in(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (ctl0 !== C_LU || cnt0 !== 32'd1) begin
            n_bad++;
            $display("FAIL load_use_rt: ctl=%b cnt=%0d, want ctl=%b cnt=1", ctl0, cnt0, C_LU);
        end
        tick();
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (ctl0 !== C_IDLE || cnt0 !== 32'd2) begin
            n_bad++;
            $display("FAIL load_use_r0: ctl=%b cnt=%0d, want ctl=%b cnt=2", ctl0, cnt0, C_IDLE);
        end
        tick();
        // register matches but the ID instruction does not read it
        set_in(5'd7, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (ctl0 !== C_IDLE) begin
            n_bad++;
            $display("FAIL load_use_unused: ctl=%b, want %b", ctl0, C_IDLE);
        end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (ctl0 !== C_BR || ctl1 !== C_BR) begin
            n_bad++;
            $display("FAIL branch: ctl=%b ctl1=%b, want %b", ctl0, ctl1, C_BR);
        end
        tick();
        idle_in();
        n_cmp++;
        if (cnt0 !== 32'd0 || busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL branch_cnt: cnt=%0d busy=%b, want cnt=0 busy=0", cnt0, busy0);
        end
        tick();
    endtask

    task automatic test_muldiv();
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, (c == 1), 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (ctl0 !== ((c <= 4) ? C_MD : C_IDLE) || busy0 !== (c >= 2 && c <= 4)) begin
                n_bad++;
                $display("FAIL muldiv_c%0d: ctl=%b busy=%b, want ctl=%b busy=%b", c, ctl0, busy0,
                         (c <= 4) ? C_MD : C_IDLE, (c >= 2 && c <= 4));
            end
            n_cmp++;
            if (ctl1 !== ((c == 1) ? C_MD : C_IDLE) || busy1 !== 1'b0) begin
                n_bad++;
                $display("FAIL md1_c%0d: ctl=%b busy=%b, want ctl=%b busy=0", c, ctl1, busy1,
                         (c == 1) ? C_MD : C_IDLE);
            end
            tick();
        end
        idle_in();
        n_cmp++;
        if (cnt0 !== 32'd4 || cnt1 !== 32'd1) begin
            n_bad++;
            $display("FAIL muldiv_cnt: cnt=%0d cnt1=%0d, want 4 and 1", cnt0, cnt1);
        end
    endtask

    task automatic test_dmem_overlap();
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, (c == 1), 1'b0, (c == 2 || c == 3), 1'b0);
            n_cmp++;
            if (ctl0 !== ((c == 2 || c == 3) ? C_DMEM : (c <= 4) ? C_MD : C_IDLE)) begin
                n_bad++;
                $display("FAIL dmem_md_c%0d: ctl=%b, want %b", c, ctl0,
                         (c == 2 || c == 3) ? C_DMEM : (c <= 4) ? C_MD : C_IDLE);
            end
            tick();
        end
        idle_in();
        n_cmp++;
        if (cnt0 !== 32'd4 || busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL dmem_md_cnt: cnt=%0d busy=%b, want 4 and 0", cnt0, busy0);
        end
    endtask

    task automatic test_halt();
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (ctl0 !== C_IDLE || busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_cycle: ctl=%b busy=%b, want %b busy=0", ctl0, busy0, C_IDLE);
        end
        tick();
        for (int c = 0; c < 10; c++) begin
            set_in(5'($urandom), 5'($urandom), 1'b1, 1'b1, 5'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            n_cmp++;
            if (ctl0 !== C_OFF || busy0 !== 1'b1 || cnt0 !== 32'd0) begin
                n_bad++;
                $display("FAIL halted_%0d: ctl=%b busy=%b cnt=%0d, want %b busy=1 cnt=0",
                         c, ctl0, busy0, cnt0, C_OFF);
            end
            tick();
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (ctl0 !== C_OFF || busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_reset: ctl=%b busy=%b, want %b busy=0", ctl0, busy0, C_OFF);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (ctl0 !== C_MD || busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_run_after: ctl=%b busy=%b, want %b busy=0", ctl0, busy0, C_MD);
        end
        tick();
        idle_in();
        n_cmp++;
        if (busy0 !== 1'b1) begin
            n_bad++;
            $display("FAIL halt_md_after: busy=%b, want 1", busy0);
        end
        do_reset();
    endtask

    task automatic test_random();
        int since_halt;
        do_reset();
        since_halt = 0;
        for (int i = 0; i < 600; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                   1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 99) == 0));
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if ((k == 0 ? ctl0 : ctl1) !== e_ctl[k] || (k == 0 ? busy0 : busy1) !== e_busy[k] ||
                    (k == 0 ? cnt0 : cnt1) !== m_cnt[k]) begin
                    n_bad++;
                    $display("FAIL random_%0d_dut%0d: ctl=%b busy=%b cnt=%0d, want ctl=%b busy=%b cnt=%0d",
                             i, k, (k == 0 ? ctl0 : ctl1), (k == 0 ? busy0 : busy1),
                             (k == 0 ? cnt0 : cnt1), e_ctl[k], e_busy[k], m_cnt[k]);
                end
            end
            tick();
            if (m_halt[0]) since_halt++;
            if (since_halt > 4) begin
                do_reset();
                since_halt = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv();
        test_dmem_overlap();
        test_halt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage CPU (IF/ID/EX/MEM/WB). It sits directly upstream of the PC register and the four inter-stage pipeline registers. It drives their `we` (hold) and synchronous-clear inputs, so that it freezes, bubbles or squashes stages on load-use hazards, taken branches, multi-cycle mul/div, data-memory wait and halt. It also keeps a stall-cycle performance counter.

## Interface
Parameters:
- `MD_CYCLES`, default 4: total stall cycles for a mul/div in EX. Legal range is 1 to 64.
- `CNT_W`, default 32: width of the stall-cycle counter.

Ports:
- `clk`, input, 1: clock. Rising edge is active.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `id_rs`, `id_rt`, input, 5 each: source register numbers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt`, input, 1 each: ID instruction actually reads rs / rt.
- `ex_rd`, input, 5: destination register of the instruction in EX.
- `ex_mem_read`, input, 1: EX instruction is a load.
- `ex_md_start`, input, 1: EX instruction is a mul/div. Sampled in state RUN only.
- `branch_taken`, input, 1: branch/jump in EX resolved taken.
- `dmem_stall`, input, 1: data memory has not completed the MEM access this cycle.
- `halt`, input, 1: halt/syscall retiring in WB.
- `pc_we`, `ifid_we`, `idex_we`, `exmem_we`, `memwb_we`, output, 1 each: load enables for the PC and the pipeline registers.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`, output, 1 each: synchronous clear of the corresponding pipeline register. Each clear inserts a bubble.
- `busy`, output, 1: state is not RUN.
- `stall_cycles`, output, CNT_W: count of cycles with `pc_we`=0 since reset.

## Operation
- FSM states are RUN, MD_WAIT and HALTED. A down-counter `md_cnt` uses $clog2(MD_CYCLES+1) bits.
- The control outputs are combinational from state and inputs. Defaults are all `*_we`=1 and all `*_flush`=0.
- Priority, highest first:
  1. HALTED. All `*_we`=0 and all `*_flush`=0. The only exit is reset.
  2. `dmem_stall`=1. `pc_we`, `ifid_we`, `idex_we` and `exmem_we` are 0; `memwb_flush`=1. The FSM and `md_cnt` still advance.
  3. MD_WAIT, or RUN with `ex_md_start`=1 and `branch_taken`=0. `pc_we`, `ifid_we` and `idex_we` are 0; `exmem_flush`=1; `memwb_we`=1.
  4. `branch_taken`=1. `pc_we`=1 so the PC loads the target; `ifid_flush`=1 and `idex_flush`=1. This overrides load-use and `ex_md_start`.
  5. Load-use. The condition is `ex_mem_read` and `ex_rd`≠0 and ((`id_uses_rs` and `id_rs`=`ex_rd`) or (`id_uses_rt` and `id_rt`=`ex_rd`)). Response: `pc_we`=0, `ifid_we`=0, `idex_flush`=1, with EX/MEM and MEM/WB enabled.
- When a flush is asserted, the matching `we` is don't-care, because the flush wins inside the register. The block drives that `we` to 1.
- Transitions:
  - RUN→MD_WAIT when `ex_md_start`=1, `branch_taken`=0 and MD_CYCLES>1. `md_cnt` loads MD_CYCLES−1.
  - With MD_CYCLES=1 the stall lasts exactly the start cycle and the FSM stays in RUN.
  - In MD_WAIT, `md_cnt` decrements each cycle, regardless of `dmem_stall`. The FSM returns to RUN in the cycle after `md_cnt`=1.
  - `halt`=1 in RUN or MD_WAIT moves the FSM to HALTED next cycle. The current cycle is processed normally.
- `stall_cycles` increments each cycle with `pc_we`=0 while not HALTED. It wraps modulo 2^CNT_W.
- `busy` is 1 in MD_WAIT and in HALTED.

## Timing
- Reset (`rst_n` low) is asynchronous. Reset values:
  - State is RUN, `md_cnt`=0 and `stall_cycles`=0.
  - While `rst_n` is low, all `*_we` and all `*_flush` are forced to 0 and `busy`=0.
- After deassertion, normal operation starts on the next rising edge.
- Reset mid-MD_WAIT or mid-HALTED returns immediately to RUN.
- Control outputs have zero latency: they are valid in the same cycle as their inputs and are consumed at the same edge.
- Load-use stall costs 1 cycle. Taken branch costs 2 squashed slots. Mul/div costs MD_CYCLES cycles. `dmem_stall` costs one cycle per asserted cycle.
- `ex_md_start` is sampled only in RUN, so the held EX instruction does not retrigger in MD_WAIT. When the FSM returns to RUN, EX/MEM is enabled and the mul/div moves on.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs`=5, `id_uses_rs`=1 → for 1 cycle `pc_we`=0, `ifid_we`=0, `idex_flush`=1; `stall_cycles` goes 0→1. Repeating with `ex_rd`=0 → no stall.
- Branch plus load-use in the same cycle: `branch_taken`=1 → `pc_we`=1, `ifid_flush`=1, `idex_flush`=1, `stall_cycles` unchanged.
- Mul/div with MD_CYCLES=4: a single pulse of `ex_md_start` → `pc_we`=0 and `exmem_flush`=1 for exactly 4 cycles; `busy`=1 for cycles 2–4; RUN in cycle 5; `stall_cycles`=4.
- Memory wait overlapping mul/div: `dmem_stall`=1 for 2 cycles during MD_WAIT → `memwb_flush`=1 and `memwb_we`=1 in those cycles; total mul/div stall stays 4 cycles.
- Halt: `halt`=1 → next cycle all outputs are 0 and `busy`=1, and this holds for 10 cycles; `rst_n` low mid-halt → immediately all outputs 0 and `busy`=0, and the FSM is in RUN after release.
- MD_CYCLES=1 build: `ex_md_start` → 1 stall cycle and `busy` never asserts.
